// File: rtl/calc1_pkg.sv
// Shared types and codes for the calc1 port arbiter: command/response encodings,
// slot and arbiter state enums, and the command validity check.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_OP2,
        SLOT_PEND
    } slot_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    function automatic logic cmd_valid(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc1_rr_arbiter.sv
// Combinational round-robin pick: first pending port at or after the pointer, wrapping.
// The pointer register is owned by the parent.
module calc1_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] i_pend,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_any
);

    int unsigned w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            if (!o_any && i_pend[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/calc1_port_arbiter.sv
// Multi-port front end sharing one calc1 ALU with round-robin arbitration.
// Optional ALU watchdog enabled by defining CALC1_ALU_TIMEOUT_EN.
module calc1_port_arbiter
    import calc1_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_PORTS-1:0]        cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0]   data_in,
    output logic [2*NUM_PORTS-1:0]        resp_out,
    output logic [DATA_W*NUM_PORTS-1:0]   data_out,
    output logic                          alu_start,
    output logic [3:0]                    alu_cmd,
    output logic [DATA_W-1:0]             alu_op1,
    output logic [DATA_W-1:0]             alu_op2,
    input  logic                          alu_done,
    input  logic [1:0]                    alu_resp,
    input  logic [DATA_W-1:0]             alu_result
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t          r_arb_st;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_grant_idx;
    logic                r_alu_start;
    logic [3:0]          r_alu_cmd;
    logic [DATA_W-1:0]   r_alu_op1;
    logic [DATA_W-1:0]   r_alu_op2;
    logic [1:0]          r_resp;
    logic [DATA_W-1:0]   r_result;

`ifdef CALC1_ALU_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    r_tmo;
`endif

    logic [NUM_PORTS-1:0]             w_pend;
    logic [NUM_PORTS-1:0]             w_grant_oh;
    logic [IDX_W-1:0]                 w_grant_idx;
    logic                             w_any;
    logic [NUM_PORTS-1:0][3:0]        w_slot_cmd;
    logic [NUM_PORTS-1:0][DATA_W-1:0] w_slot_op1;
    logic [NUM_PORTS-1:0][DATA_W-1:0] w_slot_op2;
    logic [3:0]                       w_sel_cmd;
    logic [DATA_W-1:0]                w_sel_op1;
    logic [DATA_W-1:0]                w_sel_op2;
    logic                             w_resp_cycle;

    assign w_resp_cycle = (r_arb_st == ARB_RESP);

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
            slot_state_t       r_st;
            logic [3:0]        r_cmd;
            logic [DATA_W-1:0] r_op1;
            logic [DATA_W-1:0] r_op2;
            logic [3:0]        w_cmd;
            logic [DATA_W-1:0] w_data;
            logic              w_done;
            logic              w_accept;

            assign w_cmd  = cmd_in[4*g +: 4];
            assign w_data = data_in[DATA_W*g +: DATA_W];
            assign w_done = w_resp_cycle && (r_grant_idx == IDX_W'(g));
            // The response cycle frees the slot, so a new command may land in it.
            assign w_accept = (r_st == SLOT_EMPTY) || ((r_st == SLOT_PEND) && w_done);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_st  <= SLOT_EMPTY;
                    r_cmd <= CMD_NOP;
                    r_op1 <= '0;
                    r_op2 <= '0;
                end else if (w_accept) begin
                    if (w_cmd != CMD_NOP) begin
                        r_cmd <= w_cmd;
                        r_op1 <= w_data;
                        r_st  <= SLOT_OP2;
                    end else begin
                        r_st  <= SLOT_EMPTY;
                    end
                end else if (r_st == SLOT_OP2) begin
                    r_op2 <= w_data;
                    r_st  <= SLOT_PEND;
                end
            end

            assign w_pend[g]     = (r_st == SLOT_PEND);
            assign w_slot_cmd[g] = r_cmd;
            assign w_slot_op1[g] = r_op1;
            assign w_slot_op2[g] = r_op2;
        end
    endgenerate

    calc1_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .i_pend      (w_pend),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    always_comb begin
        w_sel_cmd = '0;
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_cmd = w_sel_cmd | w_slot_cmd[i];
                w_sel_op1 = w_sel_op1 | w_slot_op1[i];
                w_sel_op2 = w_sel_op2 | w_slot_op2[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arb_st    <= ARB_IDLE;
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_alu_start <= 1'b0;
            r_alu_cmd   <= CMD_NOP;
            r_alu_op1   <= '0;
            r_alu_op2   <= '0;
            r_resp      <= RESP_NONE;
            r_result    <= '0;
`ifdef CALC1_ALU_TIMEOUT_EN
            r_tmo       <= '0;
`endif
        end else begin
            r_alu_start <= 1'b0;
            case (r_arb_st)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant_idx <= w_grant_idx;
                        if (cmd_valid(w_sel_cmd)) begin
                            r_alu_cmd   <= w_sel_cmd;
                            r_alu_op1   <= w_sel_op1;
                            r_alu_op2   <= w_sel_op2;
                            r_alu_start <= 1'b1;
                            r_arb_st    <= ARB_ISSUE;
                        end else begin
                            r_resp   <= RESP_ERR;
                            r_result <= '0;
                            r_arb_st <= ARB_RESP;
                        end
                    end
                end
                ARB_ISSUE: begin
                    r_arb_st <= ARB_WAIT;
`ifdef CALC1_ALU_TIMEOUT_EN
                    r_tmo    <= '0;
`endif
                end
                ARB_WAIT: begin
                    if (alu_done) begin
                        r_resp   <= alu_resp;
                        r_result <= alu_result;
                        r_arb_st <= ARB_RESP;
`ifdef CALC1_ALU_TIMEOUT_EN
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_resp   <= RESP_ERR;
                        r_result <= '0;
                        r_arb_st <= ARB_RESP;
                    end else begin
                        r_tmo    <= r_tmo + 1'b1;
`endif
                    end
                end
                ARB_RESP: begin
                    r_ptr    <= (r_grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : r_grant_idx + 1'b1;
                    r_arb_st <= ARB_IDLE;
                end
                default: r_arb_st <= ARB_IDLE;
            endcase
        end
    end

    assign alu_start = r_alu_start;
    assign alu_cmd   = r_alu_cmd;
    assign alu_op1   = r_alu_op1;
    assign alu_op2   = r_alu_op2;

    always_comb begin
        resp_out = '0;
        data_out = '0;
        if (w_resp_cycle) begin
            resp_out[r_grant_idx*2 +: 2]           = r_resp;
            data_out[r_grant_idx*DATA_W +: DATA_W] = r_result;
        end
    end

endmodule

// File: tb/tb_calc1_port_arbiter.sv
// Scoreboard bench for calc1_port_arbiter with a behavioural ALU model.
// The watchdog scenario runs only when CALC1_ALU_TIMEOUT_EN is defined.
module tb_calc1_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*NP-1:0] cmd_in;
    logic [DW*NP-1:0] data_in;
    logic [2*NP-1:0] resp_out;
    logic [DW*NP-1:0] data_out;
    logic            alu_start;
    logic [3:0]      alu_cmd;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic            alu_done;
    logic [1:0]      alu_resp;
    logic [DW-1:0]   alu_result;

    calc1_port_arbiter #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_in     (cmd_in),
        .data_in    (data_in),
        .resp_out   (resp_out),
        .data_out   (data_out),
        .alu_start  (alu_start),
        .alu_cmd    (alu_cmd),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_done   (alu_done),
        .alu_resp   (alu_resp),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int port;
        int cyc;
    } rlog_t;

    exp_t        exp_q[$];
    rlog_t       resp_log[$];
    logic [31:0] start_log[$];
    int          start_cyc[$];

    int checks = 0;
    int failures = 0;

    bit          alu_en = 1'b1;
    bit          stray_done = 1'b0;
    int          alu_cnt = 0;
    logic [3:0]  m_cmd;
    logic [31:0] m_a;
    logic [31:0] m_b;

    function automatic logic [33:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            4'd1:    return {2'd1, a + b};
            4'd2:    return {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'h0};
        endcase
    endfunction

    // ALU model: answers one cycle after alu_start unless disabled.
    always @(negedge clk) begin
        if (reset) begin
            alu_done   = 1'b0;
            alu_resp   = 2'd0;
            alu_result = '0;
            alu_cnt    = 0;
        end else begin
            alu_done = 1'b0;
            if (alu_cnt > 0) begin
                alu_cnt = alu_cnt - 1;
                if (alu_cnt == 0) begin
                    alu_done = 1'b1;
                    {alu_resp, alu_result} = alu_fn(m_cmd, m_a, m_b);
                end
            end
            if (stray_done) begin
                alu_done   = 1'b1;
                alu_resp   = 2'd1;
                alu_result = 32'hAAAA_AAAA;
            end
            if (alu_start) begin
                start_log.push_back(alu_op1);
                start_cyc.push_back(cyc);
                if (alu_en) begin
                    m_cmd   = alu_cmd;
                    m_a     = alu_op1;
                    m_b     = alu_op2;
                    alu_cnt = 1;
                end
            end
        end
    end

    // Response monitor and scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            int nresp;
            nresp = 0;
            for (int p = 0; p < NP; p++) begin
                if (resp_out[2*p +: 2] != 2'd0) begin
                    int idx;
                    nresp++;
                    resp_log.push_back('{port: p, cyc: cyc});
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && exp_q[i].port == p) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        failures++;
                        $display("FAIL unexpected_resp port=%0d got resp=%0d data=%h want no response",
                                 p, resp_out[2*p +: 2], data_out[DW*p +: DW]);
                    end else begin
                        if (resp_out[2*p +: 2] !== exp_q[idx].resp ||
                            data_out[DW*p +: DW] !== exp_q[idx].data) begin
                            failures++;
                            $display("FAIL resp_data port=%0d got resp=%0d data=%h want resp=%0d data=%h",
                                     p, resp_out[2*p +: 2], data_out[DW*p +: DW],
                                     exp_q[idx].resp, exp_q[idx].data);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
            if (nresp != 0) begin
                checks++;
                if (nresp != 1) begin
                    failures++;
                    $display("FAIL one_resp_per_cycle got %0d responders want 1", nresp);
                end
            end
        end
    end

    task automatic clear_logs();
        resp_log.delete();
        start_log.delete();
        start_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        cmd_in  = '0;
        data_in = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic send(input int p, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, output int c0);
        @(negedge clk);
        c0 = cyc;
        cmd_in[4*p +: 4]   = c;
        data_in[DW*p +: DW] = a;
        @(negedge clk);
        cmd_in[4*p +: 4]   = 4'd0;
        data_in[DW*p +: DW] = b;
        @(negedge clk);
        data_in[DW*p +: DW] = '0;
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        cmd_in  = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (resp_out !== '0) begin
            failures++;
            $display("FAIL reset_resp got %h want 0", resp_out);
        end
        checks++;
        if (data_out !== '0) begin
            failures++;
            $display("FAIL reset_data got %h want 0", data_out);
        end
        checks++;
        if ({alu_start, alu_cmd, alu_op1, alu_op2} !== '0) begin
            failures++;
            $display("FAIL reset_alu got start=%b cmd=%h op1=%h op2=%h want all 0",
                     alu_start, alu_cmd, alu_op1, alu_op2);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_single();
        int c0;
        clear_logs();
        exp_q.push_back('{port: 0, resp: 2'd1, data: 32'h3});
        send(0, 4'd1, 32'h1, 32'h2, c0);
        wait_empty(30);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_done got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (start_cyc.size() != 1 || start_cyc[0] != c0 + 3) begin
            failures++;
            $display("FAIL single_start_cycle got n=%0d want one start at %0d",
                     start_cyc.size(), c0 + 3);
        end
        checks++;
        if (resp_log.size() != 1) begin
            failures++;
            $display("FAIL single_resp_len got %0d cycles want 1", resp_log.size());
        end else begin
            checks++;
            if (resp_log[0].port != 0 || resp_log[0].cyc != c0 + 5) begin
                failures++;
                $display("FAIL single_resp_time got port=%0d cyc=%0d want port=0 cyc=%0d",
                         resp_log[0].port, resp_log[0].cyc, c0 + 5);
            end
        end
    endtask

    task automatic test_all_ports();
        int c0;
        logic [31:0] want;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            exp_q.push_back('{port: p, resp: 2'd1, data: 32'(16 * (p + 1) + p)});
        end
        @(negedge clk);
        cmd_in  = {4'd1, 4'd1, 4'd1, 4'd1};
        data_in = {32'h40, 32'h30, 32'h20, 32'h10};
        @(negedge clk);
        cmd_in  = '0;
        data_in = {32'h3, 32'h2, 32'h1, 32'h0};
        @(negedge clk);
        data_in = '0;
        wait_empty(80);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL all_done got %0d pending want 0", exp_q.size());
        end
        for (int i = 0; i < NP; i++) begin
            want = 32'(16 * (i + 1));
            checks++;
            if (i >= start_log.size() || start_log[i] !== want) begin
                failures++;
                $display("FAIL rr_order slot=%0d got %h want %h", i,
                         (i < start_log.size()) ? start_log[i] : 32'hx, want);
            end
        end
        exp_q.push_back('{port: 2, resp: 2'd1, data: 32'h10});
        send(2, 4'd1, 32'h7, 32'h9, c0);
        wait_empty(30);
        checks++;
        if (start_log.size() != NP + 1 || start_log[NP] !== 32'h7) begin
            failures++;
            $display("FAIL rr_wrap got n=%0d want start of port 2 op1 0x7", start_log.size());
        end
        checks++;
        if (resp_log.size() != NP + 1 || resp_log[NP].port != 2) begin
            failures++;
            $display("FAIL rr_wrap_resp got n=%0d want port 2 last", resp_log.size());
        end
    endtask

    task automatic test_invalid();
        int c0;
        clear_logs();
        exp_q.push_back('{port: 1, resp: 2'd2, data: 32'h0});
        send(1, 4'd4, 32'hDEAD, 32'hBEEF, c0);
        wait_empty(20);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL invalid_done got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (start_log.size() != 0) begin
            failures++;
            $display("FAIL invalid_no_start got %0d starts want 0", start_log.size());
        end
        checks++;
        if (resp_log.size() != 1 || resp_log[0].cyc != c0 + 3) begin
            failures++;
            $display("FAIL invalid_time got n=%0d want one resp at %0d", resp_log.size(), c0 + 3);
        end
    endtask

    task automatic test_pend_ignore();
        int c0;
        do_reset();
        exp_q.push_back('{port: 0, resp: 2'd1, data: 32'd11});
        exp_q.push_back('{port: 0, resp: 2'd1, data: 32'h10});
        @(negedge clk);
        c0 = cyc;
        cmd_in[3:0] = 4'd1;  data_in[31:0] = 32'd5;
        @(negedge clk);
        cmd_in[3:0] = 4'd0;  data_in[31:0] = 32'd6;
        @(negedge clk);
        cmd_in[3:0] = 4'd2;  data_in[31:0] = 32'd100;
        @(negedge clk);
        cmd_in[3:0] = 4'd0;  data_in[31:0] = 32'd200;
        @(negedge clk);
        data_in[31:0] = 32'd0;
        @(negedge clk);
        cmd_in[3:0] = 4'd6;  data_in[31:0] = 32'h80;
        @(negedge clk);
        cmd_in[3:0] = 4'd0;  data_in[31:0] = 32'd3;
        @(negedge clk);
        data_in[31:0] = 32'd0;
        wait_empty(30);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pend_done got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (resp_log.size() != 2) begin
            failures++;
            $display("FAIL pend_count got %0d want 2", resp_log.size());
        end else begin
            checks++;
            if (resp_log[0].cyc != c0 + 5 || resp_log[1].cyc != c0 + 10) begin
                failures++;
                $display("FAIL pend_times got %0d,%0d want %0d,%0d",
                         resp_log[0].cyc, resp_log[1].cyc, c0 + 5, c0 + 10);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        do_reset();
        alu_en = 1'b0;
        send(3, 4'd1, 32'h11, 32'h22, c0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({resp_out, data_out, alu_start, alu_cmd, alu_op1, alu_op2} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got resp=%h cmd=%h op1=%h want all 0",
                     resp_out, alu_cmd, alu_op1);
        end
        @(negedge clk);
        reset  = 1'b0;
        alu_en = 1'b1;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (resp_log.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_no_resp got %0d responses want 0", resp_log.size());
        end
        checks++;
        if (start_log.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_starts got %0d want 1", start_log.size());
        end
    endtask

`ifdef CALC1_ALU_TIMEOUT_EN
    task automatic test_timeout();
        int c0;
        do_reset();
        alu_en = 1'b0;
        exp_q.push_back('{port: 1, resp: 2'd2, data: 32'h0});
        send(1, 4'd1, 32'h5, 32'h6, c0);
        wait_empty(40);
        alu_en = 1'b1;
        checks++;
        if (resp_log.size() != 1 || resp_log[0].cyc != c0 + 20) begin
            failures++;
            $display("FAIL timeout_time got n=%0d want one resp at %0d", resp_log.size(), c0 + 20);
        end
        exp_q.push_back('{port: 1, resp: 2'd1, data: 32'd15});
        send(1, 4'd1, 32'd7, 32'd8, c0);
        wait_empty(30);
        checks++;
        if (exp_q.size() != 0 || resp_log.size() != 2) begin
            failures++;
            $display("FAIL timeout_recover got pending=%0d n=%0d want 0 and 2",
                     exp_q.size(), resp_log.size());
        end
    endtask
`endif

    initial begin
        stray_done = 1'b0;
        test_reset();
        test_single();
        test_all_ports();
        test_invalid();
        test_pend_ignore();
        test_reset_mid();
`ifdef CALC1_ALU_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_scoreboard got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc1_port_arbiter.md
Name: calc1_port_arbiter

Overview:
Front-end controller for the calc1 calculator datapath. It accepts two-cycle command/operand sequences on NUM_PORTS independent requester ports and shares a single external add/subtract/shift ALU between them using round-robin arbitration. It routes each ALU result back to the originating port as a one-cycle response. It sits between the per-port cmd_in/data_in/data_out interface and the ALU core.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- DATA_W, 32, operand/result width.
- TIMEOUT, 16, ALU watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_in  in  4*NUM_PORTS  per-port command; 0 = no-op, 1 = add, 2 = sub, 5 = shl, 6 = shr.
- data_in  in  DATA_W*NUM_PORTS  per-port data: op1 in the cmd cycle, op2 in the following cycle.
- resp_out  out  2*NUM_PORTS  per-port response; 0 = none, 1 = success, 2 = overflow/underflow/invalid/timeout.
- data_out  out  DATA_W*NUM_PORTS  per-port result; valid only while that port's resp_out != 0.
- alu_start  out  1  one-cycle pulse that launches an ALU operation.
- alu_cmd  out  4  command presented to the ALU.
- alu_op1, alu_op2  out  DATA_W each  ALU operands; held stable from alu_start until alu_done.
- alu_done  in  1  ALU completion pulse.
- alu_resp  in  2  ALU status, sampled when alu_done = 1.
- alu_result  in  DATA_W  ALU result, sampled when alu_done = 1.

Behaviour:
- Reset: all outputs 0. All port slots are set to EMPTY, the arbiter goes to IDLE and the round-robin pointer is set to 0. Reset asserted mid-operation aborts everything immediately; no response is ever produced for aborted requests.
- Per-port capture FSM:
  - EMPTY: when cmd_in != 0, latch cmd and op1 and go to OP2.
  - OP2: latch data_in as op2 unconditionally and go to PEND.
  - PEND: wait for a grant. cmd_in is ignored while the slot is in OP2 or PEND (one outstanding request per port).
  - The slot returns to EMPTY in the cycle its response is driven. A nonzero cmd_in sampled in that same cycle is accepted.
- Arbiter FSM:
  - IDLE: if any slot is PEND, grant the first PEND port at or after the pointer (wrapping).
    - Valid command: go to ISSUE.
    - Invalid command (not 1/2/5/6): go directly to RESP with resp = 2 and data = 0. The ALU is not touched.
  - ISSUE: alu_start = 1 for exactly one cycle; go to WAIT.
  - WAIT: on alu_done, register alu_resp and alu_result, then go to RESP. alu_done seen in any other state is ignored.
  - RESP: drive the granted port's resp_out/data_out for exactly one cycle, set pointer = grant + 1 (mod NUM_PORTS), then go to IDLE.
- Latency: cmd at cycle c, op2 at c+1, grant decision at c+2, alu_start at c+3. With alu_done at c+4, the response appears at c+5. Each operation adds 1 cycle of arbitration overhead.
- Non-granted ports' resp_out is always 0. At most one port responds per cycle.
- Data is passed through unmodified. Overflow detection belongs to the ALU.

Optional Feature:
- CALC1_ALU_TIMEOUT_EN
  - Defined: a counter runs in WAIT. If alu_done is not seen within TIMEOUT cycles of entering WAIT, the arbiter goes to RESP with resp = 2 and data = 0. A late alu_done is then ignored.
  - Undefined: no counter; WAIT holds indefinitely.

Decomposition:
- Package calc1_pkg: command codes (CMD_NOP/ADD/SUB/SHL/SHR), response codes (RESP_NONE/OK/ERR), slot and arbiter state enums, and a cmd_valid function.
- Sub-module calc1_rr_arbiter: takes a pending vector and the pointer, and produces a one-hot grant plus a grant index. It is purely combinational; the pointer register lives in the parent.
- Per-port capture slots are built with a generate loop in the parent.

Test Plan:
- Port 0 sends cmd=1, op1 = 0x1, op2 = 0x2; the ALU model answers (1, 0x3) one cycle after start -> resp_out[0] = 1 and data_out[0] = 0x3 for exactly one cycle, at cmd + 5. Ports 1–3 resp_out stay 0.
- All 4 ports issue add in the same cycle with pointer = 0 -> alu_start order is ports 0, 1, 2, 3. Then port 2 alone issues -> it is granted next (pointer = 0 after port 3, wraps to port 2).
- Port 1 sends cmd=4 -> resp_out[1] = 2, data_out[1] = 0, and alu_start never pulses.
- Port 0 sends a second cmd while PEND -> it is ignored; exactly one response. A cmd sent in the response cycle is accepted and produces a second response.
- Reset asserted during WAIT, then a stray alu_done -> all outputs are 0 and no response is generated afterwards.
- With CALC1_ALU_TIMEOUT_EN and TIMEOUT = 16, the ALU never answers -> resp 2 and data 0 at WAIT entry + 16. A subsequent request completes normally.
